// File: rtl/mem_to_stream_reader_if.sv
// Bundles the BRAM read port and the outgoing pixel stream of the frame reader.
// Stream handshake: a beat transfers on every rising edge where out_valid and
// out_ready are both high; once out_valid rises, out_data/out_last hold steady
// and out_valid stays high until that transfer happens. out_ready may change
// freely and never depends combinationally on out_valid.
interface mem_to_stream_reader_if #(
    parameter int N = 17,
    parameter int D = 16
);
    logic         ena;
    logic [N-1:0] addr;
    logic         wea;
    logic [D-1:0] douta;
    logic         out_valid;
    logic         out_ready;
    logic [D-1:0] out_data;
    logic         out_last;

    modport master (
        output ena, addr, wea, out_valid, out_data, out_last,
        input  douta, out_ready
    );

    modport slave (
        input  ena, addr, wea, out_valid, out_data, out_last,
        output douta, out_ready
    );
endinterface

// File: rtl/mem_to_stream_reader.sv
// Reads a ROWS x COLS frame out of a single-port BRAM in raster order and
// streams it through a 2-entry skid buffer that absorbs the 1-cycle read
// latency and downstream backpressure.
module mem_to_stream_reader #(
    parameter int N          = 17,
    parameter int n          = 9,
    parameter int D          = 16,
    parameter int ROWS       = 128,
    parameter int COLS       = 128,
    parameter int ROW_STRIDE = 128,
    parameter int BASE       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            dbg_state,
    mem_to_stream_reader_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [n-1:0] LAST_ROW = n'(ROWS - 1);
    localparam logic [n-1:0] LAST_COL = n'(COLS - 1);
    localparam logic [N-1:0] BASE_A   = N'(BASE);
    localparam logic [N-1:0] STRIDE_A = N'(ROW_STRIDE);

    state_t       state, next_state;
    logic [n-1:0] row, col;
    logic [1:0]   occ;
    logic         in_flight;
    logic         in_flight_last;
    logic [D-1:0] buf_data [2];
    logic         buf_last [2];
    logic         issue, push, pop, at_end;

    assign at_end    = (row == LAST_ROW) && (col == LAST_COL);
    assign push      = in_flight;
    assign pop       = bus.out_valid & bus.out_ready;
    assign bus.ena   = issue;
    assign bus.wea   = 1'b0;
    assign bus.addr  = BASE_A + N'(row) * STRIDE_A + N'(col);
    assign bus.out_valid = (occ != 2'd0);
    assign bus.out_data  = buf_data[0];
    // Stale last flags may linger in the head slot after draining; gate them.
    assign bus.out_last  = buf_last[0] & bus.out_valid;
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next state, read issue and status outputs. A read is issued only when
    // the buffer is guaranteed a free slot by the time its data returns.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = READ;
            end
            READ: begin
                busy  = 1'b1;
                issue = ({1'b0, occ} + {2'b00, in_flight}) < (3'd2 + {2'b00, pop});
                if (issue && at_end) next_state = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if ((occ == 2'd0) && !in_flight) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Raster counters; after the final pixel they return to (0,0) so the
    // address never leaves the frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (state == IDLE && start) begin
            row <= '0;
            col <= '0;
        end else if (issue) begin
            if (col == LAST_COL) begin
                col <= '0;
                row <= at_end ? '0 : row + n'(1);
            end else begin
                col <= col + n'(1);
            end
        end
    end

    // Track the read whose data arrives on douta next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
        end else begin
            in_flight      <= issue;
            in_flight_last <= issue & at_end;
        end
    end

    // Skid buffer: slot 0 is the head; pops shift slot 1 forward.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
                buf_last[i] <= 1'b0;
            end
        end else begin
            case ({push, pop})
                2'b10: begin
                    buf_data[occ[0]] <= bus.douta;
                    buf_last[occ[0]] <= in_flight_last;
                    occ              <= occ + 2'd1;
                end
                2'b01: begin
                    buf_data[0] <= buf_data[1];
                    buf_last[0] <= buf_last[1];
                    occ         <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd2) begin
                        buf_data[0] <= buf_data[1];
                        buf_last[0] <= buf_last[1];
                        buf_data[1] <= bus.douta;
                        buf_last[1] <= in_flight_last;
                    end else begin
                        buf_data[0] <= bus.douta;
                        buf_last[0] <= in_flight_last;
                    end
                end
                default: ;
            endcase
        end
    end

    // A push into a full buffer without a simultaneous pop would drop a pixel.
    always @(posedge clk) begin
        if (!reset && push && !pop) assert (occ != 2'd2);
    end
endmodule

// File: tb/tb_mem_to_stream_reader.sv
// Bench for mem_to_stream_reader: two instances (frame at 0 and at 0x4000),
// BRAM models holding mem[a] = a[15:0], and a pixel scoreboard built from the
// raster-order definition of the frame.
module tb_mem_to_stream_reader;
    localparam int N          = 17;
    localparam int D          = 16;
    localparam int ROWS       = 128;
    localparam int COLS       = 128;
    localparam int ROW_STRIDE = 128;
    localparam int BASE0      = 0;
    localparam int BASE1      = 16384;
    localparam int PIXELS     = ROWS * COLS;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start0, start1, ready0, ready1;
    logic       busy0, busy1, done0, done1;
    logic [1:0] st0, st1;

    mem_to_stream_reader_if #(.N(N), .D(D)) bus0 ();
    mem_to_stream_reader_if #(.N(N), .D(D)) bus1 ();

    assign bus0.out_ready = ready0;
    assign bus1.out_ready = ready1;

    always_ff @(posedge clk) if (bus0.ena) bus0.douta <= bus0.addr[15:0];
    always_ff @(posedge clk) if (bus1.ena) bus1.douta <= bus1.addr[15:0];

    mem_to_stream_reader #(.BASE(BASE0)) u_dut0 (
        .clk(clk), .reset(rst), .start(start0), .busy(busy0), .done(done0),
        .dbg_state(st0), .bus(bus0)
    );
    mem_to_stream_reader #(.BASE(BASE1)) u_dut1 (
        .clk(clk), .reset(rst), .start(start1), .busy(busy1), .done(done1),
        .dbg_state(st1), .bus(bus1)
    );

    // Observed instance selector.
    logic         sel;
    logic         m_valid, m_ready, m_last, m_ena, m_wea, m_busy, m_done;
    logic [D-1:0] m_data;
    logic [N-1:0] m_addr;
    logic [1:0]   m_state;
    always_comb begin
        if (sel) begin
            m_valid = bus1.out_valid; m_ready = ready1; m_last = bus1.out_last;
            m_ena = bus1.ena; m_wea = bus1.wea; m_busy = busy1; m_done = done1;
            m_data = bus1.out_data; m_addr = bus1.addr; m_state = st1;
        end else begin
            m_valid = bus0.out_valid; m_ready = ready0; m_last = bus0.out_last;
            m_ena = bus0.ena; m_wea = bus0.wea; m_busy = busy0; m_done = done0;
            m_data = bus0.out_data; m_addr = bus0.addr; m_state = st0;
        end
    end

    // ---------------- scoreboard state ----------------
    int checks, errors, cyc;
    logic [D-1:0] exp_q[$];
    int issued, accepted, beats, done_cnt, done_cyc;
    int first_valid_cyc, first_ena_cyc, last_beat_cyc, start_cyc;
    logic [N-1:0] first_ena_addr, max_addr;
    logic [D-1:0] first_data, last_data, prev_data;
    logic prev_stall, prev_last, prev_busy, busy_at_done, busy_before_done;
    logic restarted;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        issued = 0; accepted = 0; beats = 0; done_cnt = 0; done_cyc = -1;
        first_valid_cyc = -1; first_ena_cyc = -1; last_beat_cyc = -1;
        first_ena_addr = '0; max_addr = '0; first_data = '0; last_data = '0;
        prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; prev_busy = 1'b0;
        busy_at_done = 1'b0; busy_before_done = 1'b0;
    endtask

    // Expected frame: raster order, column fastest.
    task automatic arm(input int base);
        clear_model();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                exp_q.push_back(16'(base + r * ROW_STRIDE + c));
    endtask

    // Per-cycle observation of the selected instance.
    task automatic monitor();
        logic [D-1:0] e;
        check("wea_zero", 32'(m_wea), 0);
        check("outstanding_le2", 32'((issued - accepted) <= 2), 1);
        if (prev_stall) begin
            check("stall_valid", 32'(m_valid), 1);
            check("stall_data", 32'(m_data), 32'(prev_data));
            check("stall_last", 32'(m_last), 32'(prev_last));
        end
        if (m_ena) begin
            if (first_ena_cyc < 0) begin
                first_ena_cyc  = cyc;
                first_ena_addr = m_addr;
            end
            issued++;
        end
        if (m_addr > max_addr) max_addr = m_addr;
        if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (m_valid && m_ready) begin
            check("beat_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("beat_data", 32'(m_data), 32'(e));
                check("beat_last", 32'(m_last), 32'(exp_q.size() == 0));
            end
            if (beats == 0) first_data = m_data;
            last_data = m_data;
            accepted++; beats++; last_beat_cyc = cyc;
        end
        if (m_done) begin
            done_cnt++; done_cyc = cyc;
            busy_at_done = m_busy; busy_before_done = prev_busy;
        end
        prev_busy  = m_busy;
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        #1;
        monitor();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic launch(input int base);
        arm(base);
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        start_cyc = cyc;
        tick();
        start0 = 1'b0; start1 = 1'b0;
    endtask

    task automatic run_to_done(input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            tick();
            k++;
        end
        check("done_seen", 32'(done_cnt), 1);
    endtask

    task automatic check_reset(input int base);
        #1;
        check("rst_busy", 32'(m_busy), 0);
        check("rst_done", 32'(m_done), 0);
        check("rst_ena", 32'(m_ena), 0);
        check("rst_wea", 32'(m_wea), 0);
        check("rst_valid", 32'(m_valid), 0);
        check("rst_last", 32'(m_last), 0);
        check("rst_addr", 32'(m_addr), base);
        check("rst_state", 32'(m_state), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        checks = 0; errors = 0; cyc = 0; restarted = 1'b0;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; ready0 = 1'b0; ready1 = 1'b0; sel = 1'b0;
        clear_model();
        @(negedge clk);
        repeat (3) tick();
        rst = 1'b0;
        sel = 1'b1; check_reset(BASE1);
        sel = 1'b0; check_reset(BASE0);

        // Full frame, downstream always ready, start at cycle 10.
        ready0 = 1'b1;
        while (cyc < 10) tick();
        launch(BASE0);
        #1 check("busy_after_start", 32'(m_busy), 1);
        run_to_done(PIXELS + 100);
        repeat (4) tick();
        check("a_first_ena_cyc", first_ena_cyc, start_cyc + 1);
        check("a_first_ena_addr", 32'(first_ena_addr), BASE0);
        check("a_first_valid_cyc", first_valid_cyc, start_cyc + 3);
        check("a_first_data", 32'(first_data), 0);
        check("a_last_beat_cyc", last_beat_cyc, start_cyc + 3 + PIXELS - 1);
        check("a_done_cyc", done_cyc, start_cyc + PIXELS + 4);
        check("a_beats", beats, PIXELS);
        check("a_queue_empty", exp_q.size(), 0);
        check("a_busy_at_done", 32'(busy_at_done), 0);
        check("a_busy_before_done", 32'(busy_before_done), 1);
        check("a_done_count", done_cnt, 1);
        check("a_state_idle", 32'(m_state), 0);

        // Initial 20-cycle stall, then random ready with a stray start at pixel 500.
        ready0 = 1'b0;
        launch(BASE0);
        for (int i = 0; i < 20; i++) begin
            if (i == 15) begin
                #1;
                check("stall_ena_off", 32'(m_ena), 0);
                check("stall_out_valid", 32'(m_valid), 1);
                check("stall_occupancy", issued - accepted, 2);
            end
            tick();
        end
        begin
            int k = 0;
            while (done_cnt == 0 && k < 4 * PIXELS) begin
                ready0 = 1'($urandom_range(0, 1));
                if (beats == 500 && !restarted) begin
                    start0 = 1'b1;
                    restarted = 1'b1;
                end else begin
                    start0 = 1'b0;
                end
                tick();
                k++;
            end
            start0 = 1'b0;
        end
        check("b_done_seen", done_cnt, 1);
        ready0 = 1'b1;
        repeat (6) tick();
        check("b_restart_hit", 32'(restarted), 1);
        check("b_beats", beats, PIXELS);
        check("b_queue_empty", exp_q.size(), 0);
        check("b_done_count", done_cnt, 1);
        check("b_state_idle", 32'(m_state), 0);

        // Reset in the middle of a frame, then a fresh start.
        ready0 = 1'b1;
        launch(BASE0);
        begin
            int k = 0;
            while (!(beats >= 8000 && m_valid) && k < PIXELS) begin
                tick();
                k++;
            end
        end
        check("c_abort_valid", 32'(m_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
        check_reset(BASE0);
        repeat (30) tick();
        check("c_no_done", done_cnt, 0);
        check("c_state_idle", 32'(m_state), 0);
        launch(BASE0);
        repeat (40) tick();
        check("c_first_valid_cyc", first_valid_cyc, start_cyc + 3);
        check("c_first_data", 32'(first_data), 0);
        check("c_beats", beats, 38);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();

        // Frame at BASE 0x4000.
        sel = 1'b1;
        ready1 = 1'b1;
        repeat (2) tick();
        launch(BASE1);
        run_to_done(PIXELS + 100);
        repeat (4) tick();
        check("d_first_ena_addr", 32'(first_ena_addr), 32'h4000);
        check("d_first_data", 32'(first_data), 32'h4000);
        check("d_last_data", 32'(last_data), 32'h7FFF);
        check("d_max_addr", 32'(max_addr), 32'h7FFF);
        check("d_beats", beats, PIXELS);
        check("d_done_count", done_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
